// File: rtl/fpu_sig_div.sv
// Radix-2 restoring divider for normalized significands.
// Produces an integer bit, FRACW fraction bits, guard and round bits, plus a sticky bit.
module fpu_sig_div #(
   parameter int FRACW = 10
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [FRACW:0]     sigA,
   input  logic [FRACW:0]     sigB,
   output logic [FRACW+2:0]   quot,
   output logic               sticky,
   output logic               busy,
   output logic               done,
   output logic               divZero
);

   localparam int NITER = FRACW + 3;
   localparam int SW    = FRACW + 1;
   localparam int RW    = FRACW + 2;
   localparam int CW    = $clog2(NITER + 1);
   localparam logic [CW-1:0] LAST = CW'(NITER - 1);

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t            state_q, state_d;
   logic [RW-1:0]     rem_q, rem_d;
   logic [SW-1:0]     dvs_q, dvs_d;
   logic [NITER-1:0]  quot_q, quot_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sticky_q, sticky_d;
   logic              dz_q, dz_d;

   logic              ge;
   logic [RW-1:0]     rem_sub;

   // The remainder stays below twice the divisor, so RW bits never overflow.
   assign ge      = (rem_q >= {1'b0, dvs_q});
   assign rem_sub = ge ? (rem_q - {1'b0, dvs_q}) : rem_q;

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      dvs_d    = dvs_q;
      quot_d   = quot_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      dz_d     = dz_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d    = '0;
               sticky_d = 1'b0;
               if (sigB == '0) begin
                  state_d = DONE;
                  quot_d  = '1;
                  dz_d    = 1'b1;
               end else begin
                  state_d = ITER;
                  rem_d   = {1'b0, sigA};
                  dvs_d   = sigB;
                  quot_d  = '0;
                  dz_d    = 1'b0;
               end
            end
         end
         ITER: begin
            quot_d = {quot_q[NITER-2:0], ge};
            rem_d  = rem_sub << 1;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d  = DONE;
               sticky_d = (rem_sub != '0);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         rem_q    <= '0;
         dvs_q    <= '0;
         quot_q   <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         dvs_q    <= dvs_d;
         quot_q   <= quot_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         dz_q     <= dz_d;
      end
   end

   assign quot    = quot_q;
   assign sticky  = sticky_q;
   assign divZero = dz_q;
   assign busy    = (state_q == ITER);
   assign done    = (state_q == DONE);

endmodule
